// File: rtl/sonic_eth_10g_tx_pause_timer.sv
// sonic_eth_10g_tx_pause_timer: holds off 10G TX for received 802.3x pause quanta, counting down after the in-flight frame ends
module sonic_eth_10g_tx_pause_timer #(
    parameter int QUANTA_CYCLES = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [15:0]          in_data,
    output logic                 in_ready,
    input  logic                 tx_idle,
    output logic                 pause_req,
    output logic                 pause_active,
    output logic [15:0]          pause_remaining,
    output logic [CNT_WIDTH-1:0] pause_events
);
    typedef enum logic [1:0] {IDLE, WAIT_EOF, PAUSED} state_t;
    localparam logic [7:0] SUB_LAST = 8'(QUANTA_CYCLES - 1);
    state_t state;
    logic [7:0] sub;
    logic accept, zero_q, quantum_end;
    assign accept = in_valid && in_ready;
    assign zero_q = in_data == 16'd0;
    assign quantum_end = sub == SUB_LAST;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sub <= 8'd0;
            in_ready <= 1'b0;
            pause_req <= 1'b0;
            pause_active <= 1'b0;
            pause_remaining <= 16'd0;
            pause_events <= '0;
        end else begin
            in_ready <= 1'b1;
            if (accept && !zero_q && !(&pause_events))
                pause_events <= pause_events + CNT_WIDTH'(1);
            case (state)
                IDLE:
                    if (accept && !zero_q) begin
                        state <= WAIT_EOF;
                        pause_req <= 1'b1;
                        pause_remaining <= in_data;
                        sub <= 8'd0;
                    end
                WAIT_EOF:
                    if (accept && zero_q) begin
                        state <= IDLE;
                        pause_req <= 1'b0;
                        pause_remaining <= 16'd0;
                    end else begin
                        if (accept)
                            pause_remaining <= in_data;
                        if (tx_idle) begin
                            state <= PAUSED;
                            pause_active <= 1'b1;
                            sub <= 8'd0;
                        end
                    end
                PAUSED:
                    // a new beat always wins over the local countdown (replace semantics)
                    if (accept && !zero_q) begin
                        pause_remaining <= in_data;
                        sub <= 8'd0;
                    end else if (accept || (quantum_end && pause_remaining <= 16'd1)) begin
                        state <= IDLE;
                        pause_req <= 1'b0;
                        pause_active <= 1'b0;
                        pause_remaining <= 16'd0;
                        sub <= 8'd0;
                    end else if (quantum_end) begin
                        sub <= 8'd0;
                        pause_remaining <= pause_remaining - 16'd1;
                    end else begin
                        sub <= sub + 8'd1;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sonic_eth_10g_tx_pause_timer.sv
// tb_sonic_eth_10g_tx_pause_timer: directed and random stimulus against a cycle-budget model of the pause timer
module tb_sonic_eth_10g_tx_pause_timer;
    localparam int QC = 8;
    localparam int CW = 4;
    localparam int EV_MAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic tx_idle = 1'b0;
    logic in_ready, pause_req, pause_active;
    logic [15:0] pause_remaining;
    logic [CW-1:0] pause_events;
    int checks = 0;
    int errors = 0;
    // model: 0 idle, 1 waiting for end of frame, 2 paused with m_left cycles still to go
    int m_mode = 0;
    int m_q = 0;
    int m_left = 0;
    int m_ev = 0;
    bit m_ready = 0;
    int n;

    sonic_eth_10g_tx_pause_timer #(.QUANTA_CYCLES(QC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx_idle(tx_idle), .pause_req(pause_req),
        .pause_active(pause_active), .pause_remaining(pause_remaining),
        .pause_events(pause_events)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int rem;
        rem = m_mode == 1 ? m_q : m_mode == 2 ? (m_left + QC - 1) / QC : 0;
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("pause_req", 32'(pause_req), 32'(m_mode != 0));
        check("pause_active", 32'(pause_active), 32'(m_mode == 2));
        check("pause_remaining", 32'(pause_remaining), 32'(rem));
        check("pause_events", 32'(pause_events), 32'(m_ev));
    endtask

    task automatic step();
        bit acc, tx;
        int q;
        acc = in_valid && m_ready;
        q = int'(in_data);
        tx = tx_idle;
        @(posedge clk);
        #1;
        if (acc && q > 0 && m_ev < EV_MAX) m_ev++;
        if (m_mode == 0) begin
            if (acc && q > 0) begin m_mode = 1; m_q = q; end
        end else if (m_mode == 1) begin
            if (acc && q == 0) m_mode = 0;
            else begin
                if (acc) m_q = q;
                if (tx) begin m_mode = 2; m_left = m_q * QC; end
            end
        end else begin
            if (acc && q > 0) m_left = q * QC;
            else if (acc) m_mode = 0;
            else begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end
        m_ready = 1;
        check_all();
    endtask

    task automatic beat(input int q);
        in_valid = 1'b1;
        in_data = 16'(q);
        step();
        in_valid = 1'b0;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic count_active(output int cnt);
        cnt = 0;
        while (pause_active && cnt < 2000) begin
            step();
            cnt++;
        end
    endtask

    task automatic zero_check();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_pause_req", 32'(pause_req), 32'd0);
        check("rst_pause_active", 32'(pause_active), 32'd0);
        check("rst_pause_remaining", 32'(pause_remaining), 32'd0);
        check("rst_pause_events", 32'(pause_events), 32'd0);
        m_mode = 0; m_q = 0; m_left = 0; m_ev = 0; m_ready = 0;
    endtask

    initial begin
        #3 zero_check();
        #5 reset_n = 1'b1;
        step();
        // basic q=3 with tx idle
        tx_idle = 1'b1;
        beat(3);
        step();
        count_active(n);
        check("q3_active_cycles", 32'(n), 32'd24);
        run(3);
        // held off by an in-flight frame
        tx_idle = 1'b0;
        beat(2);
        run(10);
        tx_idle = 1'b1;
        step();
        count_active(n);
        check("q2_active_cycles", 32'(n), 32'd16);
        // reload at remaining=40, sub=5
        beat(40);
        step();
        run(5);
        beat(100);
        count_active(n);
        check("reload_active_cycles", 32'(n), 32'd800);
        // cancel in PAUSED at remaining=7, then zero beat in IDLE
        beat(10);
        step();
        run(3 * QC);
        check("pre_cancel_remaining", 32'(pause_remaining), 32'd7);
        beat(0);
        run(2);
        beat(0);
        run(2);
        // reload on the final decrement of a q=1 pause
        beat(1);
        step();
        run(QC - 1);
        beat(5);
        check("reload_on_last_active", 32'(pause_active), 32'd1);
        count_active(n);
        check("reload_on_last_cycles", 32'(n), 32'd40);
        // saturation of the 4-bit event counter
        for (int i = 0; i < 20; i++) beat(1);
        check("events_saturated", 32'(pause_events), 32'(EV_MAX));
        run(4);
        // asynchronous reset mid-pause
        #2 reset_n = 1'b0;
        #1 zero_check();
        #2 reset_n = 1'b1;
        step();
        // random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid = $urandom_range(7) == 0;
            in_data = $urandom_range(3) == 0 ? 16'd0 : 16'($urandom_range(6, 1));
            tx_idle = 1'($urandom_range(1));
            step();
        end
        in_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
